// File: rtl/adpll_chan_seq.sv
// Channel sequencer for an ADPLL: powers the loop down, applies a new FCW/mode,
// waits for lock with retries and timeout, and watches for loss of lock.
module adpll_chan_seq #(
  parameter int FCWW      = 26,
  parameter int SETTLE    = 8,
  parameter int LOCK_TMO  = 1023,
  parameter int MAX_RETRY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [FCWW-1:0] req_fcw,
  input  logic [1:0]      req_mode,
  input  logic            abort,
  output logic [FCWW-1:0] adpll_fcw,
  output logic [1:0]      adpll_mode,
  input  logic            channel_lock,
  output logic            busy,
  output logic            locked,
  output logic            lol,
  output logic [1:0]      err,
  output logic [1:0]      retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_PWRDN, S_APPLY, S_LOCKED, S_FAIL
  } state_t;

  localparam logic [1:0] M_PD   = 2'd0;
  localparam logic [1:0] M_TEST = 2'd1;

  localparam logic [1:0] E_NONE    = 2'd0;
  localparam logic [1:0] E_TIMEOUT = 2'd1;
  localparam logic [1:0] E_BADMODE = 2'd2;
  localparam logic [1:0] E_ABORTED = 2'd3;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [9:0] TMO_LAST    = 10'(LOCK_TMO);
  localparam logic [1:0] RETRY_MAX   = 2'(MAX_RETRY);
  localparam logic [9:0] BLANK_END   = 10'd2;

  state_t            state_q, state_d;
  logic [FCWW-1:0]   fcw_q, fcw_d;
  logic [1:0]        amode_q, amode_d;
  logic [1:0]        mode_q, mode_d;
  logic [1:0]        err_q, err_d;
  logic [1:0]        retry_q, retry_d;
  logic              lol_q, lol_d;
  logic [7:0]        settle_q, settle_d;
  logic [9:0]        timer_q, timer_d;

  logic              ready_w;
  logic              accept_w;
  logic              abort_w;

  // State register: every register also holds while en is low, reset wins over en.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      fcw_q    <= '0;
      amode_q  <= M_PD;
      mode_q   <= M_PD;
      err_q    <= E_NONE;
      retry_q  <= 2'd0;
      lol_q    <= 1'b0;
      settle_q <= 8'd0;
      timer_q  <= 10'd0;
    end else begin
      state_q  <= state_d;
      fcw_q    <= fcw_d;
      amode_q  <= amode_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      retry_q  <= retry_d;
      lol_q    <= lol_d;
      settle_q <= settle_d;
      timer_q  <= timer_d;
    end
  end

  assign accept_w = en & req_valid & ready_w & ~abort;
  assign abort_w  = en & abort &
                    ((state_q == S_PWRDN) || (state_q == S_APPLY) || (state_q == S_LOCKED));

  // Next-state logic. Priority: abort, accept, then the per-state behaviour.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    fcw_d    = fcw_q;
    amode_d  = amode_q;
    mode_d   = mode_q;
    err_d    = err_q;
    retry_d  = retry_q;
    lol_d    = lol_q;
    settle_d = settle_q;
    timer_d  = timer_q;

    if (en) begin
      // Counters restart on every state entry; the pulse lasts one enabled cycle.
      lol_d    = 1'b0;
      settle_d = 8'd0;
      timer_d  = 10'd0;

      if (abort_w) begin
        state_d = S_IDLE;
        amode_d = M_PD;
        err_d   = E_ABORTED;
      end else if (accept_w) begin
        err_d   = E_NONE;
        retry_d = 2'd0;
        mode_d  = req_mode;
        amode_d = M_PD;
        if (req_mode == M_PD) begin
          state_d = S_IDLE;
          fcw_d   = req_fcw;
        end else if (req_mode == M_TEST) begin
          state_d = S_FAIL;
          err_d   = E_BADMODE;
        end else begin
          state_d = S_PWRDN;
          fcw_d   = req_fcw;
        end
      end else begin
        unique case (state_q)
          S_PWRDN: begin
            if (settle_q == SETTLE_LAST) begin
              state_d = S_APPLY;
              amode_d = mode_q;
            end else begin
              state_d  = S_PWRDN;
              settle_d = settle_q + 8'd1;
            end
          end
          S_APPLY: begin
            // Lock is blanked for the first two cycles so a stale indication is ignored.
            if (channel_lock && (timer_q >= BLANK_END)) begin
              state_d = S_LOCKED;
            end else if (timer_q == TMO_LAST) begin
              amode_d = M_PD;
              if (retry_q < RETRY_MAX) begin
                state_d = S_PWRDN;
                retry_d = retry_q + 2'd1;
              end else begin
                state_d = S_FAIL;
                err_d   = E_TIMEOUT;
              end
            end else begin
              timer_d = timer_q + 10'd1;
            end
          end
          S_LOCKED: begin
            if (!channel_lock) begin
              state_d = S_PWRDN;
              amode_d = M_PD;
              retry_d = 2'd0;
              lol_d   = 1'b1;
            end
          end
          S_IDLE, S_FAIL: ;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Output logic: status decoded from the current state only.
  always_comb begin
    ready_w = 1'b0;
    busy    = 1'b0;
    locked  = 1'b0;
    unique case (state_q)
      S_IDLE, S_FAIL: ready_w = 1'b1;
      S_PWRDN, S_APPLY: busy = 1'b1;
      S_LOCKED: begin
        ready_w = 1'b1;
        locked  = 1'b1;
      end
      default: ready_w = 1'b0;
    endcase
  end

  assign req_ready  = ready_w;
  assign adpll_fcw  = fcw_q;
  assign adpll_mode = amode_q;
  assign lol        = lol_q;
  assign err        = err_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_adpll_chan_seq.sv
// Directed bench for adpll_chan_seq with default parameters (SETTLE=8,
// LOCK_TMO=1023, MAX_RETRY=2); inputs change and outputs are sampled 1ns after posedge.
module tb_adpll_chan_seq;

  localparam int FCWW = 26;

  logic            clk = 1'b0;
  logic            rst, en, req_valid, req_ready, abort, channel_lock;
  logic [FCWW-1:0] req_fcw, adpll_fcw;
  logic [1:0]      req_mode, adpll_mode, err, retry_cnt;
  logic            busy, locked, lol;

  int pass_cnt  = 0;
  int total_cnt = 0;

  adpll_chan_seq #(.FCWW(FCWW), .SETTLE(8), .LOCK_TMO(1023), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_fcw(req_fcw), .req_mode(req_mode),
    .abort(abort), .adpll_fcw(adpll_fcw), .adpll_mode(adpll_mode),
    .channel_lock(channel_lock), .busy(busy), .locked(locked), .lol(lol),
    .err(err), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] m, input logic [FCWW-1:0] f);
    req_valid = 1'b1;
    req_mode  = m;
    req_fcw   = f;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    tick();
    total_cnt++; if (adpll_fcw !== 26'h0) $display("FAIL rst_fcw got %0h want 0", adpll_fcw); else pass_cnt++;
    total_cnt++; if (adpll_mode !== 2'd0) $display("FAIL rst_mode got %0d want 0", adpll_mode); else pass_cnt++;
    total_cnt++; if ({err, retry_cnt} !== 4'd0) $display("FAIL rst_err_retry got %0h want 0", {err, retry_cnt}); else pass_cnt++;
    total_cnt++; if ({lol, busy, locked, req_ready} !== 4'b0001)
      $display("FAIL rst_flags got %b want 0001", {lol, busy, locked, req_ready}); else pass_cnt++;
    rst = 1'b0; en = 1'b1;
  endtask

  task automatic test_rx_lock();
    apply_reset();
    channel_lock = 1'b0;
    send(2'd2, 26'h0A00000);
    total_cnt++; if ({busy, req_ready, adpll_mode} !== 4'b1000)
      $display("FAIL rx_pwrdn got %b want 1000", {busy, req_ready, adpll_mode}); else pass_cnt++;
    total_cnt++; if (adpll_fcw !== 26'h0A00000) $display("FAIL rx_fcw got %0h want a00000", adpll_fcw); else pass_cnt++;
    repeat (7) tick();
    total_cnt++; if (adpll_mode !== 2'd0) $display("FAIL rx_settle_end got %0d want 0", adpll_mode); else pass_cnt++;
    tick();
    total_cnt++; if (adpll_mode !== 2'd2) $display("FAIL rx_apply_mode got %0d want 2", adpll_mode); else pass_cnt++;
    repeat (40) tick();
    channel_lock = 1'b1;
    total_cnt++; if (locked !== 1'b0) $display("FAIL rx_not_yet_locked got %b want 0", locked); else pass_cnt++;
    tick();
    total_cnt++; if ({locked, busy, req_ready, err} !== 5'b10100)
      $display("FAIL rx_locked got %b want 10100", {locked, busy, req_ready, err}); else pass_cnt++;
  endtask

  task automatic test_lol();
    apply_reset();
    channel_lock = 1'b0;
    send(2'd2, 26'h1234567);
    repeat (8) tick();
    channel_lock = 1'b1;
    repeat (3) tick();
    total_cnt++; if (locked !== 1'b1) $display("FAIL lol_setup_locked got %b want 1", locked); else pass_cnt++;
    channel_lock = 1'b0;
    tick();
    total_cnt++; if ({lol, busy, locked, adpll_mode} !== 5'b11000)
      $display("FAIL lol_pulse got %b want 11000", {lol, busy, locked, adpll_mode}); else pass_cnt++;
    total_cnt++; if (adpll_fcw !== 26'h1234567) $display("FAIL lol_fcw got %0h want 1234567", adpll_fcw); else pass_cnt++;
    tick();
    total_cnt++; if (lol !== 1'b0) $display("FAIL lol_one_cycle got %b want 0", lol); else pass_cnt++;
    channel_lock = 1'b1;
    repeat (6) tick();
    total_cnt++; if ({busy, adpll_mode} !== 3'b100) $display("FAIL lol_settle got %b want 100", {busy, adpll_mode}); else pass_cnt++;
    tick();
    total_cnt++; if (adpll_mode !== 2'd2) $display("FAIL lol_reapply got %0d want 2", adpll_mode); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (locked !== 1'b1) $display("FAIL lol_relock got %b want 1", locked); else pass_cnt++;
    channel_lock = 1'b0;
    send(2'd3, 26'h0BEEF00);
    total_cnt++; if ({lol, busy} !== 2'b01) $display("FAIL b2b_no_lol got %b want 01", {lol, busy}); else pass_cnt++;
    total_cnt++; if (adpll_fcw !== 26'h0BEEF00) $display("FAIL b2b_fcw got %0h want beef00", adpll_fcw); else pass_cnt++;
  endtask

  task automatic test_stuck_lock();
    apply_reset();
    channel_lock = 1'b1;
    send(2'd2, 26'h0000100);
    repeat (8) tick();
    total_cnt++; if ({busy, locked, adpll_mode} !== 4'b1010)
      $display("FAIL stuck_t0 got %b want 1010", {busy, locked, adpll_mode}); else pass_cnt++;
    tick();
    total_cnt++; if (locked !== 1'b0) $display("FAIL stuck_t1 got %b want 0", locked); else pass_cnt++;
    tick();
    total_cnt++; if (locked !== 1'b0) $display("FAIL stuck_t2 got %b want 0", locked); else pass_cnt++;
    tick();
    total_cnt++; if (locked !== 1'b1) $display("FAIL stuck_lock got %b want 1", locked); else pass_cnt++;
  endtask

  task automatic test_timeout_retry();
    apply_reset();
    channel_lock = 1'b0;
    send(2'd3, 26'h2000000);
    for (int a = 0; a < 3; a++) begin
      total_cnt++; if ({busy, adpll_mode, retry_cnt} !== {1'b1, 2'd0, 2'(a)})
        $display("FAIL tmo_attempt%0d_start got %b want %b", a, {busy, adpll_mode, retry_cnt}, {1'b1, 2'd0, 2'(a)});
      else pass_cnt++;
      repeat (8) tick();
      repeat (1023) tick();
      total_cnt++; if ({busy, adpll_mode} !== 3'b111)
        $display("FAIL tmo_attempt%0d_last got %b want 111", a, {busy, adpll_mode}); else pass_cnt++;
      tick();
    end
    total_cnt++; if ({err, adpll_mode, req_ready, busy, retry_cnt} !== 8'b01_00_1_0_10)
      $display("FAIL tmo_fail got %b want 01001010", {err, adpll_mode, req_ready, busy, retry_cnt}); else pass_cnt++;
  endtask

  task automatic test_abort();
    apply_reset();
    channel_lock = 1'b0;
    send(2'd2, 26'h0055500);
    repeat (8) tick();
    repeat (100) tick();
    abort = 1'b1; req_valid = 1'b1; req_mode = 2'd3; req_fcw = 26'h3FFFFFF;
    tick();
    total_cnt++; if ({busy, locked, req_ready, err, adpll_mode} !== 7'b001_11_00)
      $display("FAIL abort_state got %b want 0011100", {busy, locked, req_ready, err, adpll_mode}); else pass_cnt++;
    total_cnt++; if (adpll_fcw !== 26'h0055500) $display("FAIL abort_fcw got %0h want 55500", adpll_fcw); else pass_cnt++;
    tick();
    total_cnt++; if ({busy, err, adpll_fcw} !== {1'b0, 2'd3, 26'h0055500})
      $display("FAIL abort_idle_block got %0h want %0h", {busy, err, adpll_fcw}, {1'b0, 2'd3, 26'h0055500}); else pass_cnt++;
    abort = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_modes();
    send(2'd1, 26'h0ABCDEF);
    total_cnt++; if ({err, busy, req_ready, adpll_mode} !== 6'b10_0_1_00)
      $display("FAIL test_mode got %b want 100100", {err, busy, req_ready, adpll_mode}); else pass_cnt++;
    total_cnt++; if (adpll_fcw !== 26'h0055500) $display("FAIL test_mode_fcw got %0h want 55500", adpll_fcw); else pass_cnt++;
    send(2'd0, 26'h0123456);
    total_cnt++; if ({err, busy, locked, adpll_mode} !== 6'b0) $display("FAIL pd_mode got %b want 0", {err, busy, locked, adpll_mode}); else pass_cnt++;
    total_cnt++; if (adpll_fcw !== 26'h0123456) $display("FAIL pd_fcw got %0h want 123456", adpll_fcw); else pass_cnt++;
  endtask

  task automatic test_en_freeze();
    apply_reset();
    channel_lock = 1'b0;
    send(2'd3, 26'h0F0F0F0);
    repeat (8) tick();
    repeat (10) tick();
    en = 1'b0; channel_lock = 1'b1;
    repeat (50) tick();
    total_cnt++; if ({busy, locked} !== 2'b10) $display("FAIL en_hold got %b want 10", {busy, locked}); else pass_cnt++;
    en = 1'b1; channel_lock = 1'b0;
    repeat (1013) tick();
    total_cnt++; if ({busy, adpll_mode, retry_cnt} !== 5'b1_11_00)
      $display("FAIL en_timer_frozen got %b want 11100", {busy, adpll_mode, retry_cnt}); else pass_cnt++;
    tick();
    total_cnt++; if ({retry_cnt, adpll_mode} !== 4'b0100) $display("FAIL en_timeout got %b want 0100", {retry_cnt, adpll_mode}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    repeat (8) tick();
    repeat (5) tick();
    total_cnt++; if ({busy, adpll_mode, retry_cnt} !== 5'b1_11_01)
      $display("FAIL mid_setup got %b want 11101", {busy, adpll_mode, retry_cnt}); else pass_cnt++;
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1;
    total_cnt++; if ({adpll_fcw, adpll_mode, err, retry_cnt} !== 32'h0)
      $display("FAIL mid_rst_regs got %0h want 0", {adpll_fcw, adpll_mode, err, retry_cnt}); else pass_cnt++;
    total_cnt++; if ({lol, busy, locked, req_ready} !== 4'b0001)
      $display("FAIL mid_rst_flags got %b want 0001", {lol, busy, locked, req_ready}); else pass_cnt++;
    tick();
    total_cnt++; if ({lol, busy} !== 2'b00) $display("FAIL mid_rst_stays_idle got %b want 00", {lol, busy}); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; req_valid = 1'b0; req_fcw = '0; req_mode = 2'd0;
    abort = 1'b0; channel_lock = 1'b0;
    test_reset();
    test_rx_lock();
    test_lol();
    test_stuck_lock();
    test_timeout_retry();
    test_abort();
    test_modes();
    test_en_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
